keypad_entry: RTL and testbench
===============================

# keypad_entry

4x4 matrix-keypad scanner and digit-entry buffer for the board's input side. It drives columns, samples rows, and debounces whole scan frames. Each accepted key press produces a single-cycle strobe and is shifted into a 4-digit hex buffer. That buffer feeds the 7-segment display's d3..d0 nibbles, so the user can type the value shown on the digits instead of it being loaded from a constant.

## Interface

Parameters:

- sim, 0, 1 selects short simulation timing.
- SCAN_DIV, sim?4:12500, clk cycles per column dwell (12500 = 250 us at 50 MHz); must be at least 4.
- DEBOUNCE, sim?2:20, consecutive identical scan frames required for both press and release; must be at least 1.

Ports:

- clk  input  1  system clock; the only clock.
- reset  input  1  asynchronous, active-low reset.
- row  input  4  keypad rows, active-low, externally pulled up, asynchronous.
- col  output  4  column drive, active-low one-hot.
- key_valid  output  1  one-cycle strobe when a press is accepted.
- key_code  output  4  code of the last accepted key; held between strobes.
- digits  output  16  entry buffer; [15:12] is the oldest digit (d3) and [3:0] the newest (d0).

## Operation

- **Column scan**
  - A divider counts 0..SCAN_DIV-1; col_idx advances 0→1→2→3→0 on terminal count.
  - col = ~(4'b0001 << col_idx).
  - A frame is one full pass of col_idx through 0..3.
- **Row sampling**
  - row passes through a 2-flop synchronizer.
  - The synchronized row is sampled on the divider's terminal-count cycle only, before col_idx advances.
  - Pressed bits are the low bits of the sample.
- **Frame classification**, latched at the terminal count of col_idx = 3:
  - NONE: zero pressed bits in the frame.
  - ONE: exactly one pressed bit in the frame; code = keymap(row, col).
  - MULTI: two or more pressed bits in the frame.
- **Key map**, rows 0-3 × cols 0-3:
  - Row 0: 1 2 3 A
  - Row 1: 4 5 6 B
  - Row 2: 7 8 9 C
  - Row 3: E(*) 0 F(#) D
- **Debounce FSM**, acting once per frame end:
  - IDLE:
    - ONE(k): cand ← k, cnt ← 1. If DEBOUNCE = 1, accept immediately; otherwise go to PRESS_WAIT.
    - NONE or MULTI: stay.
  - PRESS_WAIT:
    - ONE(cand): cnt+1. When cnt reaches DEBOUNCE, accept and go to HELD.
    - ONE(other k): cand ← k, cnt ← 1.
    - NONE or MULTI: go to IDLE.
  - HELD:
    - NONE: cnt ← 1, go to RELEASE_WAIT (or IDLE if DEBOUNCE = 1).
    - ONE or MULTI: stay. There is no auto-repeat.
  - RELEASE_WAIT:
    - NONE: cnt+1. When cnt reaches DEBOUNCE, go to IDLE.
    - ONE or MULTI: go back to HELD without a strobe.
- **Accept action**:
  - key_valid = 1 for exactly one clk.
  - key_code ← cand.
  - digits ← {digits[11:0], cand}.
- cnt saturates; its width is clog2(DEBOUNCE+1).

## Timing

- **Reset values** (asynchronous, while reset = 0):
  - col = 4'b1110, key_valid = 0, key_code = 0, digits = 16'h0000.
  - FSM = IDLE; divider, col_idx, cnt, cand and synchronizer all 0.
- **After reset release**: the first column dwell starts on the first clk edge with reset = 1.
- **Accept latency**: key_valid rises on the clk edge after the terminal count that ends the DEBOUNCE-th consecutive ONE(k) frame. The frame of first detection counts as 1.
- **Row settling**: the sample lands SCAN_DIV-1 cycles after the column change, so at least 2 of those cycles cover the synchronizer.
- **Reset mid-operation**: everything returns to reset values immediately; an in-progress candidate is discarded.
- **Wrap-around**: buffer shifting discards digits[15:12]; key_code is not affected by overflow.

## Structure

- **Package keypad_pkg**:
  - State enum {IDLE, PRESS_WAIT, HELD, RELEASE_WAIT}.
  - Frame class enum {NONE, ONE, MULTI}.
  - Function keymap(row_idx, col_idx) returning 4 bits.
- **Sub-module keypad_debounce** (the natural split):
  - Takes frame_end, frame class and code.
  - Produces accept and code.
  - Contains the FSM and cnt.
- **Top keypad_entry**: the scan divider, column drive, synchronizer, frame classifier and digits register stay here.

## Test plan

All scenarios run with sim = 1: SCAN_DIV = 4, DEBOUNCE = 2, 16-cycle frames.

1. Hold key row1/col2 for 5 frames, then release for 3 frames → exactly one key_valid, key_code = 4'h6, digits = 16'h0006.
2. Enter 1, 2, 3, 4, each held 4 frames and released 4 frames → digits = 16'h1234. Then enter 0 → digits = 16'h2340, with 5 strobes total.
3. Press '8' for only one full frame → no key_valid, FSM returns to IDLE. Then press '*' for 3 frames → key_code = 4'hE.
4. Hold '1' and '5' together for 5 frames → no strobe. Hold '9' into HELD, add '3' for 2 frames, release both, and wait 3 frames → exactly one strobe, code 4'h9.
5. HELD on 'A', one NONE frame, then 'A' again for 3 frames → no second strobe, FSM back in HELD.
6. Assert reset in PRESS_WAIT, mid-frame → col = 4'b1110, key_valid = 0, digits = 0 within the same cycle. After release, press 'D' for 3 frames → digits = 16'h000D.

Source files
------------

// File: rtl/keypad_pkg.sv
// Shared types and helpers for the keypad scanner: FSM states, frame classes,
// the physical key map and small bit-counting helpers.
package keypad_pkg;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        HELD         = 2'd2,
        RELEASE_WAIT = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        NONE  = 2'd0,
        ONE   = 2'd1,
        MULTI = 2'd2
    } frame_class_e;

    // Legend: row 0 "1 2 3 A", row 1 "4 5 6 B", row 2 "7 8 9 C", row 3 "* 0 # D".
    function automatic logic [3:0] keymap(input logic [1:0] row_idx, input logic [1:0] col_idx);
        logic [3:0] code;
        case ({row_idx, col_idx})
            4'd0:    code = 4'h1;
            4'd1:    code = 4'h2;
            4'd2:    code = 4'h3;
            4'd3:    code = 4'hA;
            4'd4:    code = 4'h4;
            4'd5:    code = 4'h5;
            4'd6:    code = 4'h6;
            4'd7:    code = 4'hB;
            4'd8:    code = 4'h7;
            4'd9:    code = 4'h8;
            4'd10:   code = 4'h9;
            4'd11:   code = 4'hC;
            4'd12:   code = 4'hE;
            4'd13:   code = 4'h0;
            4'd14:   code = 4'hF;
            4'd15:   code = 4'hD;
            default: code = 4'h0;
        endcase
        return code;
    endfunction

    function automatic logic [2:0] popcount4(input logic [3:0] v);
        return {2'b00, v[0]} + {2'b00, v[1]} + {2'b00, v[2]} + {2'b00, v[3]};
    endfunction

    function automatic logic [1:0] onehot_idx(input logic [3:0] v);
        logic [1:0] idx;
        case (v)
            4'b0001: idx = 2'd0;
            4'b0010: idx = 2'd1;
            4'b0100: idx = 2'd2;
            4'b1000: idx = 2'd3;
            default: idx = 2'd0;
        endcase
        return idx;
    endfunction

endpackage

// File: rtl/keypad_debounce.sv
// Frame-level debounce FSM: turns a stream of classified scan frames into
// single accept pulses, one per distinct press, with no auto-repeat.
module keypad_debounce
    import keypad_pkg::*;
#(
    parameter int DEBOUNCE = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_frame_end,
    input  frame_class_e i_class,
    input  logic [3:0]   i_code,
    output logic         o_accept,
    output logic [3:0]   o_code
);

    localparam int CW = $clog2(DEBOUNCE + 1);
    localparam logic [CW-1:0] CNT_TARGET = CW'(DEBOUNCE);

    state_e          r_state;
    state_e          w_state_nxt;
    logic [CW-1:0]   r_cnt;
    logic [CW-1:0]   w_cnt_nxt;
    logic [CW-1:0]   w_cnt_inc;
    logic [3:0]      r_cand;
    logic [3:0]      w_cand_nxt;
    logic            w_accept;

    // Saturating frame counter increment.
    always_comb begin
        if (r_cnt == {CW{1'b1}}) begin
            w_cnt_inc = r_cnt;
        end else begin
            w_cnt_inc = r_cnt + CW'(1);
        end
    end

    // Next-state logic, evaluated only on frame boundaries.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_cand_nxt  = r_cand;
        w_accept    = 1'b0;
        if (i_frame_end) begin
            case (r_state)
                IDLE: begin
                    if (i_class == ONE) begin
                        w_cand_nxt = i_code;
                        w_cnt_nxt  = CW'(1);
                        if (DEBOUNCE == 1) begin
                            w_accept    = 1'b1;
                            w_state_nxt = HELD;
                        end else begin
                            w_state_nxt = PRESS_WAIT;
                        end
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end
                PRESS_WAIT: begin
                    if (i_class == ONE) begin
                        if (i_code == r_cand) begin
                            w_cnt_nxt = w_cnt_inc;
                            if (w_cnt_inc >= CNT_TARGET) begin
                                w_accept    = 1'b1;
                                w_state_nxt = HELD;
                            end else begin
                                w_state_nxt = PRESS_WAIT;
                            end
                        end else begin
                            w_cand_nxt = i_code;
                            w_cnt_nxt  = CW'(1);
                        end
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end
                HELD: begin
                    if (i_class == NONE) begin
                        w_cnt_nxt   = CW'(1);
                        w_state_nxt = (DEBOUNCE == 1) ? IDLE : RELEASE_WAIT;
                    end else begin
                        w_state_nxt = HELD;
                    end
                end
                RELEASE_WAIT: begin
                    if (i_class == NONE) begin
                        w_cnt_nxt = w_cnt_inc;
                        if (w_cnt_inc >= CNT_TARGET) begin
                            w_state_nxt = IDLE;
                        end else begin
                            w_state_nxt = RELEASE_WAIT;
                        end
                    end else begin
                        w_state_nxt = HELD;
                    end
                end
                default: begin
                    w_state_nxt = IDLE;
                end
            endcase
        end else begin
            w_state_nxt = r_state;
        end
    end

    // FSM, counter and candidate registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_cand  <= 4'h0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_cand  <= w_cand_nxt;
        end
    end

    // On an accept the incoming code always equals the candidate being committed.
    assign o_accept = w_accept;
    assign o_code   = i_code;

endmodule

// File: rtl/keypad_entry.sv
// 4x4 keypad scanner: column drive, row synchronizer, per-frame classification
// and the 4-digit hex entry buffer fed by debounced key presses.
module keypad_entry
    import keypad_pkg::*;
#(
    parameter int sim      = 0,
    parameter int SCAN_DIV = (sim != 0) ? 4 : 12500,
    parameter int DEBOUNCE = (sim != 0) ? 2 : 20
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  row,
    output logic [3:0]  col,
    output logic        key_valid,
    output logic [3:0]  key_code,
    output logic [15:0] digits
);

    localparam int DW = $clog2(SCAN_DIV);

    logic [DW-1:0]  r_div;
    logic [1:0]     r_col_idx;
    logic [1:0]     w_col_idx_nxt;
    logic [3:0]     r_sync1;
    logic [3:0]     r_sync2;
    logic           w_tc;
    logic [3:0]     w_pressed;
    logic [2:0]     w_col_hits;
    logic [1:0]     w_base_cnt;
    logic [2:0]     w_sum;
    logic [1:0]     r_acc_cnt;
    logic [1:0]     w_acc_cnt_nxt;
    logic [3:0]     r_acc_code;
    logic [3:0]     w_acc_code_nxt;
    frame_class_e   w_class_nxt;
    frame_class_e   r_class;
    logic [3:0]     r_fcode;
    logic           r_frame_end;
    logic           w_accept;
    logic [3:0]     w_code;

    assign w_tc          = (r_div == DW'(SCAN_DIV - 1));
    assign w_col_idx_nxt = r_col_idx + 2'd1;
    assign w_pressed     = ~r_sync2;
    assign w_col_hits    = popcount4(w_pressed);

    // Column dwell divider and one-hot active-low column drive.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_div     <= '0;
            r_col_idx <= 2'd0;
            col       <= 4'b1110;
        end else if (w_tc) begin
            r_div     <= '0;
            r_col_idx <= w_col_idx_nxt;
            col       <= ~(4'b0001 << w_col_idx_nxt);
        end else begin
            r_div     <= r_div + DW'(1);
        end
    end

    // Two-flop synchronizer for the asynchronous row inputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync1 <= 4'h0;
            r_sync2 <= 4'h0;
        end else begin
            r_sync1 <= row;
            r_sync2 <= r_sync1;
        end
    end

    // Running press count (saturating at 2) and code across the current frame.
    always_comb begin
        if (r_col_idx == 2'd0) begin
            w_base_cnt = 2'd0;
        end else begin
            w_base_cnt = r_acc_cnt;
        end
        w_sum = {1'b0, w_base_cnt} + w_col_hits;
        if (w_sum >= 3'd2) begin
            w_acc_cnt_nxt = 2'd2;
        end else begin
            w_acc_cnt_nxt = w_sum[1:0];
        end
        if (w_col_hits == 3'd1) begin
            w_acc_code_nxt = keymap(onehot_idx(w_pressed), r_col_idx);
        end else begin
            w_acc_code_nxt = r_acc_code;
        end
        case (w_acc_cnt_nxt)
            2'd0:    w_class_nxt = NONE;
            2'd1:    w_class_nxt = ONE;
            default: w_class_nxt = MULTI;
        endcase
    end

    // Frame accumulation; classification is latched at the last column's terminal count.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_acc_cnt   <= 2'd0;
            r_acc_code  <= 4'h0;
            r_class     <= NONE;
            r_fcode     <= 4'h0;
            r_frame_end <= 1'b0;
        end else begin
            r_frame_end <= w_tc && (r_col_idx == 2'd3);
            if (w_tc) begin
                r_acc_cnt  <= w_acc_cnt_nxt;
                r_acc_code <= w_acc_code_nxt;
                if (r_col_idx == 2'd3) begin
                    r_class <= w_class_nxt;
                    r_fcode <= w_acc_code_nxt;
                end
            end
        end
    end

    keypad_debounce #(
        .DEBOUNCE (DEBOUNCE)
    ) u_debounce (
        .clk         (clk),
        .rst_n       (reset),
        .i_frame_end (r_frame_end),
        .i_class     (r_class),
        .i_code      (r_fcode),
        .o_accept    (w_accept),
        .o_code      (w_code)
    );

    // Registered strobe, last code and shifting digit buffer.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            key_valid <= 1'b0;
            key_code  <= 4'h0;
            digits    <= 16'h0000;
        end else begin
            key_valid <= w_accept;
            if (w_accept) begin
                key_code <= w_code;
                digits   <= {digits[11:0], w_code};
            end
        end
    end

endmodule

// File: tb/tb_keypad_entry.sv
// Directed bench for keypad_entry: a keypad model drives rows from the pressed-key
// mask, and a table of hold/release steps checks strobe count, code and digits.
module tb_keypad_entry;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  row;
    logic [3:0]  col;
    logic        key_valid;
    logic [3:0]  key_code;
    logic [15:0] digits;
    logic [15:0] keys;

    int checks  = 0;
    int errors  = 0;
    int strobes = 0;
    int doubles = 0;
    logic prev_kv = 1'b0;

    typedef struct {
        logic        rst;
        logic [15:0] keys;
        int          frames;
        int          exp_strobes;
        logic [3:0]  exp_code;
        logic [15:0] exp_digits;
    } vec_t;

    vec_t vecs[$];

    always #5 clk = ~clk;

    keypad_entry #(.sim(1)) dut (
        .clk       (clk),
        .reset     (reset),
        .row       (row),
        .col       (col),
        .key_valid (key_valid),
        .key_code  (key_code),
        .digits    (digits)
    );

    // Key (r,c) at mask bit r*4+c shorts row r low while column c is driven low.
    always_comb begin
        row = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (keys[r*4+c] && !col[c]) row[r] = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (key_valid) begin
            strobes <= strobes + 1;
            if (prev_kv) doubles <= doubles + 1;
        end
        prev_kv <= key_valid;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic add(input logic rst, input logic [15:0] k, input int fr,
                       input int s, input logic [3:0] code, input logic [15:0] dg);
        vec_t v;
        v.rst = rst; v.keys = k; v.frames = fr;
        v.exp_strobes = s; v.exp_code = code; v.exp_digits = dg;
        vecs.push_back(v);
    endtask

    task automatic do_reset();
        keys  = 16'h0000;
        reset = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        reset = 1'b0;
        keys  = 16'h0000;
        #12;
        check("rst_col", {28'h0, col}, 32'he);
        check("rst_valid", {31'h0, key_valid}, 32'h0);
        check("rst_code", {28'h0, key_code}, 32'h0);
        check("rst_digits", {16'h0, digits}, 32'h0);
        @(negedge clk);
        reset = 1'b1;

        // '6' held then released
        add(1'b0, 16'h0040, 5, 1, 4'h6, 16'h0006);
        add(1'b0, 16'h0000, 3, 1, 4'h6, 16'h0006);
        // 1,2,3,4 then 0 from a fresh reset
        add(1'b1, 16'h0001, 4, 2, 4'h1, 16'h0001);
        add(1'b0, 16'h0000, 4, 2, 4'h1, 16'h0001);
        add(1'b0, 16'h0002, 4, 3, 4'h2, 16'h0012);
        add(1'b0, 16'h0000, 4, 3, 4'h2, 16'h0012);
        add(1'b0, 16'h0004, 4, 4, 4'h3, 16'h0123);
        add(1'b0, 16'h0000, 4, 4, 4'h3, 16'h0123);
        add(1'b0, 16'h0010, 4, 5, 4'h4, 16'h1234);
        add(1'b0, 16'h0000, 4, 5, 4'h4, 16'h1234);
        add(1'b0, 16'h2000, 4, 6, 4'h0, 16'h2340);
        add(1'b0, 16'h0000, 4, 6, 4'h0, 16'h2340);
        // '8' for a single frame, then '*'
        add(1'b0, 16'h0200, 1, 6, 4'h0, 16'h2340);
        add(1'b0, 16'h0000, 2, 6, 4'h0, 16'h2340);
        add(1'b0, 16'h1000, 3, 7, 4'hE, 16'h340E);
        add(1'b0, 16'h0000, 3, 7, 4'hE, 16'h340E);
        // '1'+'5' together, then '9' with '3' added while held
        add(1'b0, 16'h0021, 5, 7, 4'hE, 16'h340E);
        add(1'b0, 16'h0000, 3, 7, 4'hE, 16'h340E);
        add(1'b0, 16'h0400, 4, 8, 4'h9, 16'h40E9);
        add(1'b0, 16'h0404, 2, 8, 4'h9, 16'h40E9);
        add(1'b0, 16'h0000, 3, 8, 4'h9, 16'h40E9);
        // 'A' held, one-frame gap, 'A' again
        add(1'b0, 16'h0008, 4, 9, 4'hA, 16'h0E9A);
        add(1'b0, 16'h0000, 1, 9, 4'hA, 16'h0E9A);
        add(1'b0, 16'h0008, 3, 9, 4'hA, 16'h0E9A);
        add(1'b0, 16'h0000, 3, 9, 4'hA, 16'h0E9A);

        foreach (vecs[i]) begin
            if (vecs[i].rst) do_reset();
            keys = vecs[i].keys;
            repeat (vecs[i].frames * 16) @(posedge clk);
            #1;
            check($sformatf("v%0d_strobes", i), strobes, vecs[i].exp_strobes);
            check($sformatf("v%0d_code", i), {28'h0, key_code}, {28'h0, vecs[i].exp_code});
            check($sformatf("v%0d_digits", i), {16'h0, digits}, {16'h0, vecs[i].exp_digits});
        end

        // Asynchronous reset while 'D' is being debounced
        keys = 16'h8000;
        repeat (24) @(posedge clk);
        #3 reset = 1'b0;
        #1;
        check("mid_rst_col", {28'h0, col}, 32'he);
        check("mid_rst_valid", {31'h0, key_valid}, 32'h0);
        check("mid_rst_digits", {16'h0, digits}, 32'h0);
        keys = 16'h0000;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        keys  = 16'h8000;
        repeat (48) @(posedge clk);
        keys = 16'h0000;
        repeat (48) @(posedge clk);
        #1;
        check("post_rst_strobes", strobes, 10);
        check("post_rst_code", {28'h0, key_code}, 32'hd);
        check("post_rst_digits", {16'h0, digits}, 32'hd);
        check("strobe_width", doubles, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
